dmem_ctrl: RTL and testbench

//  Parametrised data-memory controller for the pipelined RISC-V core; replaces the combinational byte array.

---
 rtl/dmem_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-banked data memory with valid/ready request/response handshake and RISC-V load/store decode.
// Optional macro DMEM_MISALIGNED_EN: word-crossing half/word accesses take an extra SPLIT edge instead of erroring.
module dmem_ctrl #(
    parameter int MEMSIZE = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int WORDS = MEMSIZE / 4;
    localparam int AW    = $clog2(MEMSIZE);
    localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
`ifdef DMEM_MISALIGNED_EN
        S_SPLIT,
`endif
        S_RESP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_write;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [2:0]      r_f3;
    logic            r_err;
    logic            r_resp_valid;
    logic [31:0]     r_resp_rdata;
    logic            r_resp_err;
    logic [31:0]     r_lo;
    logic [31:0]     r_mem [WORDS];

    logic [1:0]      w_size_m1;
    logic            w_f3_bad;
    logic [32:0]     w_end;
    logic            w_oor;
    logic            w_misal;
    logic            w_req_err;
    logic [AW-3:0]   w_idx;
    logic [3:0]      w_mask;
    logic            w_we_lo;
    logic [31:0]     w_load;

    function automatic logic [1:0] f_size_m1(input logic [2:0] f3);
        case (f3[1:0])
            2'd1:    return 2'd1;
            2'd2:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return {{24{d[7]}}, d[7:0]};
            3'd1:    return {{16{d[15]}}, d[15:0]};
            3'd4:    return {24'd0, d[7:0]};
            3'd5:    return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Request decode: range check runs in 33 bits so addresses near 2^32 cannot wrap into range.
    assign w_size_m1 = f_size_m1(req_funct3);
    assign w_f3_bad  = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'd6) ||
                       (req_write && req_funct3[2]);
    assign w_end     = {1'b0, req_addr} + {31'd0, w_size_m1};
    assign w_oor     = w_end >= 33'(MEMSIZE);
    assign w_misal   = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));

    assign w_idx   = r_addr[AW-1:2];
    assign w_mask  = (r_f3[1:0] == 2'd0) ? 4'b0001 :
                     (r_f3[1:0] == 2'd1) ? 4'b0011 : 4'b1111;
    assign w_we_lo = (r_state == S_ACCESS) && r_write;

`ifdef DMEM_MISALIGNED_EN
    logic            r_split;
    logic [31:0]     r_hi;
    logic            w_cross;
    logic [AW-3:0]   w_idx_hi;
    logic [7:0]      w_be;
    logic [63:0]     w_wd;
    logic [63:0]     w_merged;
    logic            w_we_hi;

    assign w_cross   = ({1'b0, req_addr[1:0]} + {1'b0, w_size_m1}) > 3'd3;
    assign w_req_err = w_f3_bad || w_oor;
    assign w_idx_hi  = w_idx + 1'b1;
    assign w_be      = {4'd0, w_mask} << r_addr[1:0];
    assign w_wd      = {32'd0, r_wdata} << {r_addr[1:0], 3'b000};
    assign w_we_hi   = (r_state == S_SPLIT) && r_write;
    assign w_merged  = {r_hi, r_lo} >> {r_addr[1:0], 3'b000};
    assign w_load    = w_merged[31:0];
`else
    logic [3:0]      w_be;
    logic [31:0]     w_wd;

    assign w_req_err = w_f3_bad || w_oor || w_misal;
    assign w_be      = w_mask << r_addr[1:0];
    assign w_wd      = r_wdata << {r_addr[1:0], 3'b000};
    assign w_load    = r_lo >> {r_addr[1:0], 3'b000};
`endif

    // Storage and read capture; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we_lo && w_be[i])
                r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
`ifdef DMEM_MISALIGNED_EN
            if (w_we_hi && w_be[4+i])
                r_mem[w_idx_hi][8*i +: 8] <= w_wd[32+8*i +: 8];
`endif
        end
        if (r_state == S_ACCESS)
            r_lo <= r_mem[w_idx];
`ifdef DMEM_MISALIGNED_EN
        if (r_state == S_SPLIT)
            r_hi <= r_mem[w_idx_hi];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_f3         <= '0;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
`ifdef DMEM_MISALIGNED_EN
            r_split      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr[AW-1:0];
                        r_wdata <= req_wdata;
                        r_f3    <= req_funct3;
                        r_err   <= w_req_err;
                        r_cnt   <= '0;
`ifdef DMEM_MISALIGNED_EN
                        r_split <= w_cross;
`endif
                        if (w_req_err)
                            r_state <= S_RESP;
                        else if (LATENCY > 1)
                            r_state <= S_WAIT;
                        else
                            r_state <= S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (int'(r_cnt) >= LATENCY - 2)
                        r_state <= S_ACCESS;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                S_ACCESS: begin
`ifdef DMEM_MISALIGNED_EN
                    r_state <= r_split ? S_SPLIT : S_RESP;
`else
                    r_state <= S_RESP;
`endif
                end
`ifdef DMEM_MISALIGNED_EN
                S_SPLIT: r_state <= S_RESP;
`endif
                S_RESP: begin
                    // Outputs are registered: the first RESP cycle loads them, later cycles hold until taken.
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= r_err;
                        r_resp_rdata <= (r_err || r_write) ? 32'd0 : f_extend(r_f3, w_load);
                    end else if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = rst_n && (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl against a byte-array reference model; handles both DMEM_MISALIGNED_EN builds.
module tb_dmem_ctrl;

    localparam int MEMSIZE = 64;
    localparam int LATENCY = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int failures = 0;
    logic [7:0]  mem_m [MEMSIZE];
    logic [31:0] rd;
    logic        er;
    logic [31:0] prior8;

    always #5 clk = ~clk;

    dmem_ctrl #(.MEMSIZE(MEMSIZE), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: bytes, sizes and edge counts derived directly from the access rules.
    function automatic void model(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [2:0] f3, output logic [31:0] rdx,
                                  output logic errx, output int lat);
        int size;
        longint last;
        bit split;
        logic [31:0] v;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 :
               (f3 == 3'd1 || f3 == 3'd5) ? 2 :
               (f3 == 3'd2) ? 4 : 0;
        errx = (size == 0) || (wr && f3 >= 3'd4);
        last = longint'({32'd0, a}) + size - 1;
        if (last >= MEMSIZE) errx = 1'b1;
        split = (size > 0) && ((a % 4) + size > 4);
`ifndef DMEM_MISALIGNED_EN
        if (size > 0 && (a % size) != 0) errx = 1'b1;
`endif
        rdx = 32'd0;
        lat = errx ? 1 : (LATENCY + 1 + (split ? 1 : 0));
        if (!errx) begin
            if (wr) begin
                for (int i = 0; i < size; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v + (32'(mem_m[int'(a) + i]) << (8*i));
                if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v - (32'h1 << (8*size));
                rdx = v;
            end
        end
    endfunction

    task automatic txn(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input int hold,
                       output logic [31:0] rd_obs, output logic err_obs);
        logic [31:0] rd_exp;
        logic        err_exp;
        int          lat_exp;
        int          lat;
        bit          stable;
        logic [31:0] rd0;
        model(wr, a, wd, f3, rd_exp, err_exp, lat_exp);
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_funct3 = f3;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        stable = 1'b1;
        while (!resp_valid && lat < 40) begin
            if (req_ready) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        rd0 = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_rdata !== rd0 || req_ready) stable = 1'b0;
        end
        chk({tag, "_hold"}, 32'(stable), 32'd1);
        chk({tag, "_rdata"}, resp_rdata, rd_exp);
        chk({tag, "_err"}, 32'(resp_err), 32'(err_exp));
        rd_obs = resp_rdata;
        err_obs = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_done"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst_n is held low
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);

        for (int w = 0; w < MEMSIZE / 4; w++)
            txn("init", 1'b1, 32'(4 * w), $urandom, 3'd2, 0, rd, er);

        // Store then sign/zero-extended loads
        txn("t1_sw", 1'b1, 32'd4, 32'h8000_00F1, 3'd2, 0, rd, er);
        txn("t1_lb", 1'b0, 32'd4, 32'd0, 3'd0, 1, rd, er);
        chk("t1_lb_const", rd, 32'hFFFF_FFF1);
        txn("t1_lbu", 1'b0, 32'd7, 32'd0, 3'd4, 0, rd, er);
        chk("t1_lbu_const", rd, 32'h0000_0080);
        txn("t1_lh", 1'b0, 32'd6, 32'd0, 3'd1, 0, rd, er);
        chk("t1_lh_const", rd, 32'hFFFF_8000);

        // Response held under back-pressure
        txn("t2_lw_hold", 1'b0, 32'd0, 32'd0, 3'd2, 5, rd, er);

        // Out-of-range accesses leave memory untouched
        txn("t3_lw62", 1'b0, 32'd62, 32'd0, 3'd2, 0, rd, er);
        chk("t3_lw62_errc", 32'(er), 32'd1);
        txn("t3_sb64", 1'b1, 32'd64, 32'hAA, 3'd0, 0, rd, er);
        chk("t3_sb64_errc", 32'(er), 32'd1);
        txn("t3_lw60", 1'b0, 32'd60, 32'd0, 3'd2, 0, rd, er);
        txn("t3_wrap", 1'b0, 32'hFFFF_FFFE, 32'd0, 3'd2, 0, rd, er);

        // Word-crossing load
        txn("t4_sw0", 1'b1, 32'd0, 32'h1122_3344, 3'd2, 0, rd, er);
        txn("t4_sw4", 1'b1, 32'd4, 32'h5566_7788, 3'd2, 0, rd, er);
        txn("t4_lw2", 1'b0, 32'd2, 32'd0, 3'd2, 0, rd, er);
`ifdef DMEM_MISALIGNED_EN
        chk("t4_lw2_const", rd, 32'h7788_1122);
        txn("t4_sw3", 1'b1, 32'd3, 32'hCAFE_F00D, 3'd2, 0, rd, er);
        txn("t4_lw0", 1'b0, 32'd0, 32'd0, 3'd2, 0, rd, er);
        txn("t4_lw4", 1'b0, 32'd4, 32'd0, 3'd2, 0, rd, er);
`else
        chk("t4_lw2_errc", 32'(er), 32'd1);
`endif

        // Illegal funct3
        txn("t5_ld3", 1'b0, 32'd0, 32'd0, 3'd3, 0, rd, er);
        txn("t5_st4", 1'b1, 32'd0, 32'hFFFF_FFFF, 3'd4, 0, rd, er);
        txn("t5_lw0", 1'b0, 32'd0, 32'd0, 3'd2, 0, rd, er);

        // Reset during WAIT aborts the pending store
        prior8 = {mem_m[11], mem_m[10], mem_m[9], mem_m[8]};
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd8;
        req_wdata = 32'hDEAD_BEEF; req_funct3 = 3'd2;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_ready", 32'(req_ready), 32'd0);
        chk("t6_valid", 32'(resp_valid), 32'd0);
        chk("t6_rdata", resp_rdata, 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        txn("t6_lw8", 1'b0, 32'd8, 32'd0, 3'd2, 0, rd, er);
        chk("t6_prior", rd, prior8);

        // Randomized mix
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                            : 32'($urandom_range(0, MEMSIZE + 3));
            txn("rnd", 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                $urandom_range(0, 2), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
